// File: rtl/ir_pkg.sv
// Shared IR link definitions: transmitter state encoding and NEC-style
// default timings in 100 MHz clock cycles, reused by the receive thresholds.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_MARK,
        HDR_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } ir_state_e;

    localparam int unsigned IR_CARRIER_HALF = 1316;
    localparam int unsigned IR_HDR_ON       = 900000;
    localparam int unsigned IR_HDR_OFF      = 450000;
    localparam int unsigned IR_BIT_ON       = 56000;
    localparam int unsigned IR_ZERO_OFF     = 56000;
    localparam int unsigned IR_ONE_OFF      = 169000;
    localparam int unsigned IR_CW           = 20;

    function automatic logic is_mark(input ir_state_e s);
        return (s == HDR_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier phase generator: phase restarts high on clear and toggles every
// CARRIER_HALF enabled cycles. phase_o is the phase for the coming cycle.
module ir_carrier_gen #(
    parameter int unsigned CARRIER_HALF = ir_pkg::IR_CARRIER_HALF,
    parameter int unsigned CW           = ir_pkg::IR_CW
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic phase_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear_i) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (enable_i) begin
            if (cnt_q == CW'(CARRIER_HALF - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_d;

endmodule

// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: sends an 8-bit code MSB first as a pulse-distance
// frame (header, 8 data bits, stop burst) on/off-keying a carrier onto ir_LED.
module ir_beacon_tx #(
    parameter int unsigned CARRIER_HALF = ir_pkg::IR_CARRIER_HALF,
    parameter int unsigned HDR_ON       = ir_pkg::IR_HDR_ON,
    parameter int unsigned HDR_OFF      = ir_pkg::IR_HDR_OFF,
    parameter int unsigned BIT_ON       = ir_pkg::IR_BIT_ON,
    parameter int unsigned ZERO_OFF     = ir_pkg::IR_ZERO_OFF,
    parameter int unsigned ONE_OFF      = ir_pkg::IR_ONE_OFF,
    parameter int unsigned CW           = ir_pkg::IR_CW
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_code,
    output logic       ir_LED,
    output logic       tx_busy,
    output logic       tx_done
);

    import ir_pkg::*;

    ir_state_e     state_q, state_d;
    logic [CW-1:0] dur_q, dur_d, limit;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          done_d;
    logic          led_q, busy_q, done_q;
    logic          mark_q, mark_d, phase_next;

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            HDR_MARK:            limit = CW'(HDR_ON - 1);
            HDR_SPACE:           limit = CW'(HDR_OFF - 1);
            BIT_MARK, STOP_MARK: limit = CW'(BIT_ON - 1);
            BIT_SPACE:           limit = shift_q[7] ? CW'(ONE_OFF - 1) : CW'(ZERO_OFF - 1);
            default:             limit = '0;
        endcase

        if (state_q == IDLE) begin
            dur_d = '0;
            if (tx_start) begin
                state_d = HDR_MARK;
                shift_d = tx_code;
                idx_d   = 3'd7;
            end
        end else if (dur_q == limit) begin
            dur_d = '0;
            case (state_q)
                HDR_MARK:  state_d = HDR_SPACE;
                HDR_SPACE: state_d = BIT_MARK;
                BIT_MARK:  state_d = BIT_SPACE;
                BIT_SPACE: begin
                    if (idx_q == 3'd0) begin
                        state_d = STOP_MARK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        idx_d   = idx_q - 3'd1;
                        state_d = BIT_MARK;
                    end
                end
                STOP_MARK: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default:   state_d = IDLE;
            endcase
        end else begin
            dur_d = dur_q + 1'b1;
        end
    end

    // Every mark is entered from a non-mark state, so entry is a rising mark flag.
    assign mark_q = is_mark(state_q);
    assign mark_d = is_mark(state_d);

    ir_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF),
        .CW           (CW)
    ) u_carrier (
        .clk_i    (CLK100MHZ),
        .rst_i    (rst),
        .clear_i  (mark_d & ~mark_q),
        .enable_i (mark_q),
        .phase_o  (phase_next)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q <= IDLE;
            dur_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            led_q   <= mark_d & phase_next;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign ir_LED  = led_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Scoreboard bench for ir_beacon_tx with shortened timings: stimulus queues
// expected frames, a negedge monitor checks each frame at its tx_done pulse.
module tb_ir_beacon_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_code = 8'h00;
    logic       ir_LED, tx_busy, tx_done;

    always #5 clk = ~clk;

    ir_beacon_tx #(
        .CARRIER_HALF (2),
        .HDR_ON       (8),
        .HDR_OFF      (4),
        .BIT_ON       (4),
        .ZERO_OFF     (4),
        .ONE_OFF      (12),
        .CW           (20)
    ) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .tx_code   (tx_code),
        .ir_LED    (ir_LED),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    typedef struct {
        int         t0;
        int         blen;
        int         doff;
        int         rises;
        logic [7:0] code;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference LED waveform: 2-cycle carrier halves, 4-cycle gap 0, 12-cycle gap 1.
    function automatic void build_wave(input logic [7:0] code, output logic [255:0] w,
                                       output int len);
        w   = '0;
        len = 0;
        for (int k = 0; k < 8; k++) begin w[len] = (k % 4) < 2; len++; end
        len += 4;
        for (int b = 7; b >= 0; b--) begin
            for (int k = 0; k < 4; k++) begin w[len] = k < 2; len++; end
            len += code[b] ? 12 : 4;
        end
        for (int k = 0; k < 4; k++) begin w[len] = k < 2; len++; end
    endfunction

    // Monitor
    logic         prev_busy = 1'b0;
    logic         prev_led  = 1'b0;
    int           bstart = 0, olen = 0, orise = 0, idle_led = 0, elen;
    logic [255:0] ow = '0, ew;
    exp_t         e;

    always @(negedge clk) begin
        if (tx_busy === 1'b1 && prev_busy !== 1'b1) begin
            bstart = cyc; olen = 0; ow = '0; orise = 0; prev_led = 1'b0; idle_led = 0;
        end
        if (tx_busy === 1'b1) begin
            if (olen < 256) ow[olen] = ir_LED;
            olen++;
            if (ir_LED === 1'b1 && prev_led !== 1'b1) orise++;
            prev_led = ir_LED;
        end else if (ir_LED === 1'b1) begin
            idle_led++;
        end
        if (tx_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                build_wave(e.code, ew, elen);
                chk("busy_start", bstart - e.t0, 1);
                chk("busy_len", olen, e.blen);
                chk("done_off", cyc - e.t0, e.doff);
                chk("rises", orise, e.rises);
                chk("led_idle", idle_led, 0);
                chk("wave_len", olen, elen);
                nvec++;
                if (ow !== ew) begin
                    nerr++;
                    $display("FAIL wave code=%h actual=%h required=%h", e.code, ow, ew);
                end
            end
        end
        prev_busy = tx_busy;
    end

    task automatic push_exp(input int t0, input logic [7:0] code, input int blen,
                            input int doff);
        sb.push_back('{t0: t0, blen: blen, doff: doff, rises: 11, code: code});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    int t0;
    int ndone;

    initial begin
        // Reset held with tx_start high
        tx_start = 1'b1;
        tx_code  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", {ir_LED, tx_busy, tx_done}, 0);
        end
        rst = 1'b0;
        tx_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_busy", tx_busy, 0);

        // Plain A5 frame, then back-to-back 00 frame from the tx_done cycle
        @(negedge clk);
        tx_code = 8'hA5; tx_start = 1'b1; push_exp(cyc, 8'hA5, 112, 113);
        @(negedge clk);
        tx_start = 1'b0;
        wait_done();
        tx_code = 8'h00; tx_start = 1'b1; push_exp(cyc, 8'h00, 80, 81);
        @(negedge clk);
        tx_start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // tx_start held and tx_code toggled while busy
        tx_code = 8'hA5; tx_start = 1'b1; push_exp(cyc, 8'hA5, 112, 113);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tx_code = ~tx_code;
        end
        tx_start = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        chk("ignore_single_frame", tx_busy, 0);

        // Abort in the BIT_SPACE of bit 3 (first space cycle at T+65)
        tx_code = 8'hA5; tx_start = 1'b1; t0 = cyc;
        @(negedge clk);
        tx_start = 1'b0;
        for (int i = 0; i < 200 && cyc < t0 + 65; i++) @(negedge clk);
        chk("abort_in_space", {tx_busy, ir_LED}, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", {ir_LED, tx_busy, tx_done}, 0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Full frame after abort
        tx_code = 8'h3C; tx_start = 1'b1; push_exp(cyc, 8'h3C, 112, 113);
        @(negedge clk);
        tx_start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ir_beacon_tx.md
Name: ir_beacon_tx

Overview:
- Transmit-side counterpart of the IR sensor front end. Drives the IR emitter LED with a 38 kHz carrier, on/off-keyed into a pulse-distance frame that carries an 8-bit beacon code.
- Gives the sorting robot an active beacon. The peer's receive path classifies carrier presence over fixed windows.
- Sits between the control FSM (tx_start / tx_code) and the LED driver pin.

Parameters:
- CARRIER_HALF, 1316: clock cycles per carrier half-period (100 MHz / 38 kHz / 2).
- HDR_ON, 900000: header burst length in cycles (9 ms).
- HDR_OFF, 450000: header gap length in cycles (4.5 ms).
- BIT_ON, 56000: burst length per data bit, and length of the stop burst (560 us).
- ZERO_OFF, 56000: gap after a '0' bit burst.
- ONE_OFF, 169000: gap after a '1' bit burst.
- CW, 20: width of the duration counter. Must hold max(all durations)-1.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- tx_start  input  1  request a frame. Sampled only in IDLE.
- tx_code  input  8  beacon code. Latched on the cycle tx_start is accepted.
- ir_LED  output  1  registered emitter drive; 1 = LED on.
- tx_busy  output  1  high from the first header cycle through the last stop-burst cycle.
- tx_done  output  1  one-cycle pulse in the first IDLE cycle after a completed frame.

Behaviour:
- Reset: one clock and reset, synchronous and active-high. When rst=1 at a clock edge: state=IDLE, all counters 0, ir_LED=0, tx_busy=0, tx_done=0.
  - Reset mid-frame aborts the frame immediately.
  - An aborted frame produces no tx_done.
- States: IDLE, HDR_MARK, HDR_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
- IDLE: if tx_start=1 at edge T, latch tx_code into shift_reg, set bit_idx=7, and enter HDR_MARK at T+1.
  - tx_busy=1 and ir_LED=1 in cycle T+1.
- Duration counter: cleared on every state entry. The state is left when dur_cnt == duration-1 for that state.
  - HDR_MARK -> HDR_SPACE after HDR_ON cycles.
  - HDR_SPACE -> BIT_MARK after HDR_OFF cycles.
  - BIT_MARK -> BIT_SPACE after BIT_ON cycles.
  - BIT_SPACE lasts ONE_OFF if shift_reg[7]=1, else ZERO_OFF. At its end: if bit_idx==0 go to STOP_MARK; otherwise shift left by 1, decrement bit_idx, and go to BIT_MARK.
  - STOP_MARK -> IDLE after BIT_ON cycles, with tx_done=1 in that first IDLE cycle.
- Bit order: MSB first.
- Carrier: a phase counter plus a phase bit are cleared on every MARK-state entry.
  - Phase bit starts at 1 and toggles every CARRIER_HALF cycles.
  - ir_LED = phase bit in MARK states, 0 in SPACE states and IDLE.
  - Every burst therefore starts LED-high with a deterministic edge count.
- tx_start while busy: ignored. tx_code changes while busy: ignored.
- Back-to-back: tx_start high in the tx_done cycle is accepted. HDR_MARK starts the next cycle, so the frames are separated by exactly 1 idle cycle.
- Counter widths: dur_cnt and phase counter are both CW bits and never wrap. The state exit happens before overflow.

Decomposition:
- Shared package ir_pkg holds:
  - the state enum;
  - the NEC-style default timing constants (cycles at 100 MHz), so the receiver thresholds derive from the same numbers.
- One natural sub-module: ir_carrier_gen (enable/clear in, phase bit out, CARRIER_HALF parameter).

Test Plan:
All scenarios use these overrides unless stated: CARRIER_HALF=2, HDR_ON=8, HDR_OFF=4, BIT_ON=4, ZERO_OFF=4, ONE_OFF=12.
- Reset: hold rst 3 cycles with tx_start=1 -> ir_LED=0, tx_busy=0, tx_done=0 throughout. Nothing starts until rst=0.
- Frame timing: tx_start pulse at T with tx_code=8'hA5 ->
  - tx_busy high for exactly 112 cycles (T+1..T+112);
  - tx_done=1 only at T+113.
- Waveform check, same frame ->
  - header LED pattern 11001100 then 0000;
  - each data burst 1100;
  - gap lengths 12,4,12,4,4,12,4,12;
  - stop burst 1100;
  - total ir_LED rising edges = 2+8+1 = 11.
- Busy ignore: tx_start held high and tx_code toggled during the frame -> frame identical to the 8'hA5 case, single tx_done.
- Back-to-back: tx_start asserted in the tx_done cycle with tx_code=8'h00 -> second header begins the next cycle; second frame busy for 12+64+4 = 80 cycles.
- Abort: rst=1 for 1 cycle during BIT_SPACE of bit 3 -> next cycle ir_LED=0 and tx_busy=0, no tx_done. A following tx_start produces a full, correct frame.
